bp_me_io_cmd_arbiter: RTL and testbench
=======================================

# bp_me_io_cmd_arbiter

- Shares one I/O memory-command channel (cce_mem_msg format) between `num_req_p` loaders/masters on the host side, e.g. the CCE config loader and the NBF loader ahead of the host link.
- Uses round-robin arbitration for commands.
- Records the winning requester of every accepted command in an in-order tag FIFO, and uses it to route each returning response to the requester that issued the command.
- Replaces fixed-priority muxing between loaders and makes concurrent loaders legal.

## Interface
Parameters:
- `num_req_p`, 2, number of requesters (≥2).
- `msg_width_p`, 128, width of one command/response message (cce_mem_msg).
- `max_outstanding_p`, 4, tag FIFO depth: maximum commands in flight without responses (power of 2, ≥2).

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `req_cmd_i`  in  num_req_p*msg_width_p  per-requester command; requester i occupies bits [i*msg_width_p +: msg_width_p].
- `req_cmd_v_i`  in  num_req_p  per-requester command valid.
- `req_cmd_ready_o`  out  num_req_p  per-requester command ready.
- `req_resp_o`  out  msg_width_p  response, broadcast to all requesters.
- `req_resp_v_o`  out  num_req_p  per-requester response valid (one-hot or zero).
- `req_resp_ready_i`  in  num_req_p  per-requester response ready.
- `cmd_o`  out  msg_width_p  downstream command.
- `cmd_v_o`  out  1  downstream command valid.
- `cmd_ready_i`  in  1  downstream command ready.
- `resp_i`  in  msg_width_p  downstream response.
- `resp_v_i`  in  1  downstream response valid.
- `resp_yumi_o`  out  1  downstream response consumed.
- `error_o`  out  1  sticky error: a response arrived with no command outstanding.

## Operation
- **Round-robin pointer** `ptr_r` (clog2(num_req_p) bits).
  - Grant goes to the first i with `req_cmd_v_i[i]`, searching ptr_r, ptr_r+1, … modulo num_req_p.
  - The grant is combinational from `req_cmd_v_i` and `ptr_r`.
- **Downstream command:** `cmd_v_o = |req_cmd_v_i & ~full_r`; `cmd_o` = granted requester's command. `cmd_o` is don't-care when `cmd_v_o=0`.
- **Command accept:** `req_cmd_ready_o[i] = grant[i] & cmd_ready_i & ~full_r`.
  - A handshake occurs when `cmd_v_o & cmd_ready_i`.
  - On a handshake: push the grant index into the tag FIFO, and set `ptr_r` to grant+1 modulo num_req_p.
  - With no handshake, `ptr_r` holds.
- **Requester contract:** `req_cmd_v_i` must not depend combinationally on `req_cmd_ready_o`. Once asserted, it holds with a stable command until accepted.
- **Tag FIFO:** depth max_outstanding_p, in order; the downstream returns responses in command order.
  - `full_r` and `empty_r` are registered.
  - A push and a pop in the same cycle are legal when not full. When full, a same-cycle pop does NOT admit a push; the push is admitted the next cycle.
- **Response routing when FIFO not empty:**
  - `req_resp_v_o[head] = resp_v_i`; `req_resp_o = resp_i`.
  - `resp_yumi_o = resp_v_i & req_resp_ready_i[head]`.
  - The pop occurs on `resp_yumi_o`.
  - A requester that is not ready stalls all responses; there is no bypass.
- **Spurious response (FIFO empty while `resp_v_i`=1):**
  - `resp_yumi_o=1` (drop); `req_resp_v_o=0`.
  - `error_o` sets the next cycle and stays 1 until reset.
- **Reset (asynchronous, any time including mid-transfer):**
  - `ptr_r=0`, FIFO empty (`full_r=0`), `error_o=0`.
  - While `reset_i`=1, force `req_cmd_ready_o=0`, `cmd_v_o=0`, `req_resp_v_o=0`, `resp_yumi_o=0`.
  - In-flight responses that arrive after reset are treated as spurious.

## Timing
- Command path is combinational, 0 cycles: requester to `cmd_o`/`cmd_v_o`.
- Ready path is combinational: `cmd_ready_i` to `req_cmd_ready_o`.
- Response path is combinational, 0 cycles: `resp_i` to `req_resp_o`; `req_resp_ready_i` to `resp_yumi_o`.
- Registered state: `ptr_r`, FIFO storage and pointers, `full_r`/`empty_r`, `error_o`. All update on the `clk_i` rising edge.
- Back-to-back accepts at 1 command/cycle are sustained until full.
- After a pop from full, the earliest next push is the following cycle.
- Wrap-around: FIFO read/write pointers are clog2(max_outstanding_p) bits plus a wrap bit, and wrap modulo depth. `ptr_r` wraps from num_req_p-1 to 0.

## Test plan
1. **Single requester in order:** only req0 issues 3 commands (addr 0x8000_0000, 0x8000_0040, 0x8000_0080); downstream always ready; responses returned in order. Required: commands forwarded unchanged on consecutive cycles, 3 responses with `req_resp_v_o=2'b01`, `error_o=0`.
2. **Fairness:** req0 and req1 continuously valid, `cmd_ready_i=1`, responses withheld. Required: accepted requester order 0,1,0,1; 5th command blocked with `req_cmd_ready_o=0` because full at 4.
3. **Full release:** from the full state of test 2, one response is consumed at cycle T. Required: `req_cmd_ready_o` rises at T+1 (not T); the granted requester is 0.
4. **Response backpressure:** FIFO holds tags [1,0] and `req_resp_ready_i=2'b01`. Required: `req_resp_v_o=2'b10`, `resp_yumi_o=0`; the tag-0 response is not delivered until req1 becomes ready.
5. **Spurious response:** empty FIFO, `resp_v_i=1` for 1 cycle. Required: `resp_yumi_o=1` same cycle, `req_resp_v_o=0`, `error_o=1` from the next cycle onward, cleared only by `reset_i`.
6. **Reset mid-operation:** 2 commands outstanding, `ptr_r=1`; assert `reset_i` asynchronously mid-cycle. Required: all valid/ready outputs go to 0 immediately. After release the FIFO is empty, and with both requesters valid, req0 wins first.

Source files
------------

// File: rtl/bp_me_io_cmd_arbiter.sv
// Round-robin arbiter sharing one I/O memory-command channel between num_req_p masters.
// An in-order tag FIFO remembers each winner so the returning response goes back to its issuer.
module bp_me_io_cmd_arbiter #(
   parameter int num_req_p         = 2,
   parameter int msg_width_p       = 128,
   parameter int max_outstanding_p = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
   input  logic [num_req_p-1:0]             req_cmd_v_i,
   output logic [num_req_p-1:0]             req_cmd_ready_o,
   output logic [msg_width_p-1:0]           req_resp_o,
   output logic [num_req_p-1:0]             req_resp_v_o,
   input  logic [num_req_p-1:0]             req_resp_ready_i,
   output logic [msg_width_p-1:0]           cmd_o,
   output logic                             cmd_v_o,
   input  logic                             cmd_ready_i,
   input  logic [msg_width_p-1:0]           resp_i,
   input  logic                             resp_v_i,
   output logic                             resp_yumi_o,
   output logic                             error_o
);
   localparam int ptr_w = $clog2(num_req_p);
   localparam int aw    = $clog2(max_outstanding_p);

   logic [ptr_w-1:0] ptr_q, ptr_d, grant, head;
   logic [ptr_w-1:0] mem_q [max_outstanding_p];
   logic [ptr_w-1:0] mem_d [max_outstanding_p];
   logic [aw:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic             full_q, full_d, empty_q, empty_d, error_q, error_d;
   logic             found, hs, pop;
   int               idx;

   // First valid requester at or after ptr_q, wrapping modulo num_req_p.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < num_req_p; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= num_req_p) idx = idx - num_req_p;
         if (!found && req_cmd_v_i[idx]) begin
            found = 1'b1;
            grant = ptr_w'(idx);
         end
      end
   end

   assign head    = mem_q[rptr_q[aw-1:0]];
   assign cmd_o   = req_cmd_i[grant*msg_width_p +: msg_width_p];
   assign cmd_v_o = ~reset_i & found & ~full_q;
   assign hs      = cmd_v_o & cmd_ready_i;
   assign pop     = resp_yumi_o & ~empty_q;
   assign error_o = error_q;

   // Responses with nothing outstanding are swallowed so the link never wedges.
   always_comb begin
      req_cmd_ready_o = '0;
      if (hs) req_cmd_ready_o[grant] = 1'b1;
      req_resp_o   = resp_i;
      req_resp_v_o = '0;
      resp_yumi_o  = 1'b0;
      if (!reset_i) begin
         if (empty_q) begin
            resp_yumi_o = resp_v_i;
         end else begin
            req_resp_v_o[head] = resp_v_i;
            resp_yumi_o        = resp_v_i & req_resp_ready_i[head];
         end
      end
   end

   always_comb begin
      ptr_d  = ptr_q;
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (hs) begin
         ptr_d = (grant == ptr_w'(num_req_p - 1)) ? '0 : grant + ptr_w'(1);
         mem_d[wptr_q[aw-1:0]] = grant;
         wptr_d = wptr_q + (aw+1)'(1);
      end
      if (pop) rptr_d = rptr_q + (aw+1)'(1);
      empty_d = (wptr_d == rptr_d);
      full_d  = (wptr_d[aw] != rptr_d[aw]) && (wptr_d[aw-1:0] == rptr_d[aw-1:0]);
      error_d = error_q | (resp_v_i & empty_q & ~reset_i);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         error_q <= 1'b0;
         for (int i = 0; i < max_outstanding_p; i++) mem_q[i] <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         error_q <= error_d;
         mem_q   <= mem_d;
      end
   end
endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Bench for bp_me_io_cmd_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bp_me_io_cmd_arbiter;
   localparam int N = 2, W = 128, D = 4;

   logic           clk = 1'b0, reset_i = 1'b1;
   logic [N*W-1:0] req_cmd_i;
   logic [N-1:0]   req_cmd_v_i, req_cmd_ready_o, req_resp_v_o, req_resp_ready_i;
   logic [W-1:0]   req_resp_o, cmd_o, resp_i;
   logic           cmd_v_o, cmd_ready_i, resp_v_i, resp_yumi_o, error_o;

   always #5 clk = ~clk;

   bp_me_io_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(D)) dut (
      .clk_i(clk), .reset_i(reset_i), .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i),
      .req_cmd_ready_o(req_cmd_ready_o), .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o),
      .req_resp_ready_i(req_resp_ready_i), .cmd_o(cmd_o), .cmd_v_o(cmd_v_o),
      .cmd_ready_i(cmd_ready_i), .resp_i(resp_i), .resp_v_i(resp_v_i),
      .resp_yumi_o(resp_yumi_o), .error_o(error_o));

   int total = 0, bad = 0;
   int mq[$];
   int m_ptr = 0;
   bit m_err = 1'b0;
   int acc_q[$];

   typedef struct {
      logic         cmd_v;
      int           grant;
      logic [N-1:0] rdy;
      logic [N-1:0] rv;
      logic         yumi;
   } exp_t;

   // Outputs implied by the rules, given the model's outstanding-tag list and current inputs.
   function automatic exp_t model_out();
      exp_t e;
      e.cmd_v = 1'b0; e.grant = -1; e.rdy = '0; e.rv = '0; e.yumi = 1'b0;
      if (reset_i) return e;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (e.grant < 0 && req_cmd_v_i[j]) e.grant = j;
      end
      e.cmd_v = (e.grant >= 0) && (mq.size() < D);
      if (e.cmd_v && cmd_ready_i) e.rdy[e.grant] = 1'b1;
      if (mq.size() == 0) e.yumi = resp_v_i;
      else begin
         e.rv[mq[0]] = resp_v_i;
         e.yumi = resp_v_i & req_resp_ready_i[mq[0]];
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         mq.delete();
         m_ptr <= 0;
         m_err <= 1'b0;
      end else begin
         exp_t e;
         e = model_out();
         if (e.yumi) begin
            if (mq.size() == 0) m_err <= 1'b1;
            else void'(mq.pop_front());
         end
         if (e.cmd_v && cmd_ready_i) begin
            mq.push_back(e.grant);
            m_ptr <= (e.grant + 1) % N;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      e = model_out();
      chk("m_cmd_v", W'(cmd_v_o), W'(e.cmd_v));
      chk("m_cmd_rdy", W'(req_cmd_ready_o), W'(e.rdy));
      chk("m_resp_v", W'(req_resp_v_o), W'(e.rv));
      chk("m_yumi", W'(resp_yumi_o), W'(e.yumi));
      chk("m_error", W'(error_o), W'(m_err));
      if (e.cmd_v) chk("m_cmd_o", cmd_o, req_cmd_i[e.grant*W +: W]);
      if (|e.rv) chk("m_resp_o", req_resp_o, resp_i);
      if (cmd_v_o && cmd_ready_i)
         for (int i = 0; i < N; i++) if (req_cmd_ready_o[i]) acc_q.push_back(i);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   logic [15:0] acc;

   initial begin
      req_cmd_i = '0; req_cmd_v_i = '0; req_resp_ready_i = '0;
      cmd_ready_i = 1'b0; resp_i = '0; resp_v_i = 1'b0;
      #1;
      chk("rst_cmd_v", W'(cmd_v_o), '0);
      chk("rst_error", W'(error_o), '0);
      tick(); tick();
      reset_i = 1'b0;

      // 1: single requester, three commands, in-order responses
      cmd_ready_i = 1'b1; req_resp_ready_i = 2'b11;
      for (int i = 0; i < 3; i++) begin
         req_cmd_i[W-1:0] = W'(32'h8000_0000) + W'(i * 'h40);
         req_cmd_v_i = 2'b01;
         @(negedge clk); #1;
         chk("t1_cmd_o", cmd_o, (i == 0) ? W'(32'h8000_0000) : (i == 1) ? W'(32'h8000_0040) : W'(32'h8000_0080));
         chk("t1_cmd_v", W'(cmd_v_o), W'(1));
         tick();
      end
      req_cmd_v_i = '0;
      for (int i = 0; i < 3; i++) begin
         resp_v_i = 1'b1; resp_i = W'(32'hd0 + i);
         @(negedge clk); #1;
         chk("t1_resp_v", W'(req_resp_v_o), W'(2'b01));
         tick();
      end
      resp_v_i = 1'b0;
      chk("t1_error", W'(error_o), '0);

      // 2: fairness until full
      rst_pulse();
      acc_q.delete();
      req_cmd_i = {W'(32'hB), W'(32'hA)};
      req_cmd_v_i = 2'b11; req_resp_ready_i = 2'b00;
      repeat (4) tick();
      @(negedge clk); #1;
      chk("t2_full_rdy", W'(req_cmd_ready_o), W'(2'b00));
      chk("t2_full_cmd_v", W'(cmd_v_o), '0);
      acc = 16'hFFFF;
      for (int i = 0; i < acc_q.size() && i < 4; i++) acc[4*i +: 4] = 4'(acc_q[i]);
      chk("t2_order", W'(acc), W'(16'h1010));
      chk("t2_count", W'(acc_q.size()), W'(4));

      // 3: release from full, push admitted only the cycle after the pop
      tick();
      resp_v_i = 1'b1; resp_i = W'(32'h77); req_resp_ready_i = 2'b11;
      @(negedge clk); #1;
      chk("t3_pop_yumi", W'(resp_yumi_o), W'(1));
      chk("t3_rdy_T", W'(req_cmd_ready_o), W'(2'b00));
      tick();
      resp_v_i = 1'b0;
      @(negedge clk); #1;
      chk("t3_rdy_T1", W'(req_cmd_ready_o), W'(2'b01));
      tick();
      req_cmd_v_i = '0;

      // 4: FIFO [1,0,1,0] -> drain two -> [1,0], then backpressure from req1
      resp_v_i = 1'b1; req_resp_ready_i = 2'b11;
      tick(); tick();
      req_resp_ready_i = 2'b01;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         chk("t4_stall_v", W'(req_resp_v_o), W'(2'b10));
         chk("t4_stall_yumi", W'(resp_yumi_o), '0);
         tick();
      end
      req_resp_ready_i = 2'b11;
      @(negedge clk); #1;
      chk("t4_go_yumi", W'(resp_yumi_o), W'(1));
      tick();
      @(negedge clk); #1;
      chk("t4_tag0_v", W'(req_resp_v_o), W'(2'b01));
      tick();
      resp_v_i = 1'b0;

      // 5: spurious response on empty FIFO
      chk("t5_err_pre", W'(error_o), '0);
      resp_v_i = 1'b1;
      @(negedge clk); #1;
      chk("t5_yumi", W'(resp_yumi_o), W'(1));
      chk("t5_resp_v", W'(req_resp_v_o), '0);
      tick();
      resp_v_i = 1'b0;
      chk("t5_err_set", W'(error_o), W'(1));
      repeat (3) tick();
      chk("t5_err_sticky", W'(error_o), W'(1));

      // 6: asynchronous reset with two outstanding and ptr=1
      rst_pulse();
      cmd_ready_i = 1'b1; req_resp_ready_i = 2'b00;
      req_cmd_v_i = 2'b10; tick();
      req_cmd_v_i = 2'b01; tick();
      req_cmd_v_i = 2'b11;
      #1;
      chk("t6_pre_rdy", W'(req_cmd_ready_o), W'(2'b10));
      #1;
      reset_i = 1'b1; resp_v_i = 1'b1;
      #1;
      chk("t6_rst_cmd_v", W'(cmd_v_o), '0);
      chk("t6_rst_rdy", W'(req_cmd_ready_o), W'(2'b00));
      chk("t6_rst_yumi", W'(resp_yumi_o), '0);
      chk("t6_rst_resp_v", W'(req_resp_v_o), W'(2'b00));
      tick(); tick();
      reset_i = 1'b0; resp_v_i = 1'b0;
      #1;
      chk("t6_post_rdy", W'(req_cmd_ready_o), W'(2'b01));
      chk("t6_post_err", W'(error_o), '0);
      tick();
      req_cmd_v_i = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
